fetch_sequencer: RTL and testbench

Front-end pipeline sequencer that consumes the hazard unit's `stall` and flush outputs, along with the branch-taken redirect. It owns the program counter, the IF/ID register, and the per-stage valid bits of the 5-stage, 24-bit pipeline. It drives the instruction-memory request handshake, inserts bubbles on stall, squashes stages 2–4 on a taken branch, and keeps saturating stall/flush event counters for debug.

---
 rtl/fetch_sequencer.sv | 135 +++++++++++++
 tb/tb_fetch_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: front-end sequencer for the 5-stage, 24-bit pipeline.
// Owns the PC, the IF/ID register and the downstream stage valid bits,
// drives the instruction-memory request handshake and applies the hazard
// unit's stall/flush decisions with priority flush > stall > fetch.
module fetch_sequencer #(
  parameter int              PC_W     = 24,
  parameter int              INSTR_W  = 24,
  parameter int              CNT_W    = 16,
  parameter logic [PC_W-1:0] RESET_PC = 24'h000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [PC_W-1:0]    branch_target_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_ready_i,
  input  logic [INSTR_W-1:0] imem_instr_i,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic [PC_W-1:0]    ifid_pc_o,
  output logic               ifid_valid_o,
  output logic [3:0]         stage_valid_o,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   flush_cnt_o,
  output logic [1:0]         state_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic [3:0]         stage_valid_q, stage_valid_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic active;
  logic transfer;

  // Request and address come straight from registers, so no input reaches them combinationally.
  assign imem_req_o  = (state_q == ST_RUN) || (state_q == ST_WAIT);
  assign imem_addr_o = pc_q;
  assign active      = imem_req_o;
  assign transfer    = imem_req_o & imem_ready_i;

  assign ifid_instr_o  = ifid_instr_q;
  assign ifid_pc_o     = ifid_pc_q;
  assign ifid_valid_o  = ifid_valid_q;
  assign stage_valid_o = stage_valid_q;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;
  assign state_o       = state_q;

  // Next-state logic: handshake FSM, then flush > stall > fetch for the pipeline registers.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_valid_d  = ifid_valid_q;
    stage_valid_d = stage_valid_q;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;

    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN: begin
        if (!flush_i && !stall_i && !imem_ready_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush_i || imem_ready_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (active && flush_i) begin
      // Squash ID/EX and EX/MEM; the older two stages still retire.
      pc_d          = branch_target_i;
      ifid_valid_d  = 1'b0;
      stage_valid_d = {stage_valid_q[2], stage_valid_q[1], 2'b00};
      if (flush_cnt_q != {CNT_W{1'b1}}) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end else if (active && stall_i) begin
      // Hold the front end and inject a bubble into ID/EX; any returned word is dropped.
      stage_valid_d = {stage_valid_q[2:0], 1'b0};
      if (stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end else begin
      stage_valid_d = {stage_valid_q[2:0], ifid_valid_q};
      if (transfer) begin
        ifid_instr_d = imem_instr_i;
        ifid_pc_d    = pc_q;
        ifid_valid_d = 1'b1;
        pc_d         = pc_q + 1'b1;
      end else begin
        ifid_valid_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      ifid_instr_q  <= '0;
      ifid_pc_q     <= '0;
      ifid_valid_q  <= 1'b0;
      stage_valid_q <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_valid_q  <= ifid_valid_d;
      stage_valid_q <= stage_valid_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer: reset, straight-line fetch,
// stall, flush, stall+flush, memory wait, PC wrap, async reset in WAIT
// and stall-counter saturation.
module tb_fetch_sequencer;

  localparam logic [23:0] KEY = 24'h5A5A5A;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        flush_i;
  logic [23:0] branch_target_i;
  logic        imem_req_o;
  logic [23:0] imem_addr_o;
  logic        imem_ready_i;
  logic [23:0] imem_instr_i;
  logic [23:0] ifid_instr_o;
  logic [23:0] ifid_pc_o;
  logic        ifid_valid_o;
  logic [3:0]  stage_valid_o;
  logic [15:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;
  logic [1:0]  state_o;

  int checks;
  int failures;

  fetch_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ready_i    (imem_ready_i),
    .imem_instr_i    (imem_instr_i),
    .ifid_instr_o    (ifid_instr_o),
    .ifid_pc_o       (ifid_pc_o),
    .ifid_valid_o    (ifid_valid_o),
    .stage_valid_o   (stage_valid_o),
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o),
    .state_o         (state_o)
  );

  // Clock with posedges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory returns a scrambled copy of the address as its data word.
  assign imem_instr_i = imem_addr_o ^ KEY;

  task automatic applyStimulus(input logic stall, input logic flush,
                               input logic [23:0] target, input logic ready);
    stall_i         = stall;
    flush_i         = flush;
    branch_target_i = target;
    imem_ready_i    = ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkPipe(input string tag, input logic [1:0] expState,
                           input logic [23:0] expAddr, input logic expValid,
                           input logic [23:0] expIfidPc, input logic [3:0] expStage);
    checkOutput({tag, ".state"}, 32'(state_o), 32'(expState));
    checkOutput({tag, ".addr"}, 32'(imem_addr_o), 32'(expAddr));
    checkOutput({tag, ".ifid_valid"}, 32'(ifid_valid_o), 32'(expValid));
    checkOutput({tag, ".ifid_pc"}, 32'(ifid_pc_o), 32'(expIfidPc));
    checkOutput({tag, ".stage"}, 32'(stage_valid_o), 32'(expStage));
  endtask

  task automatic checkCounters(input string tag, input logic [15:0] expStall,
                               input logic [15:0] expFlush);
    checkOutput({tag, ".stall_cnt"}, 32'(stall_cnt_o), 32'(expStall));
    checkOutput({tag, ".flush_cnt"}, 32'(flush_cnt_o), 32'(expFlush));
  endtask

  // Linear directed sequence.
  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);

    #12;
    checkPipe("reset", 2'd0, 24'h000000, 1'b0, 24'h0, 4'b0000);
    checkOutput("reset.req", 32'(imem_req_o), 32'h0);
    checkOutput("reset.instr", 32'(ifid_instr_o), 32'h0);
    checkCounters("reset", 16'h0, 16'h0);

    rst_n = 1'b1;
    tick();
    checkPipe("idle2run", 2'd1, 24'h000000, 1'b0, 24'h0, 4'b0000);
    checkOutput("idle2run.req", 32'(imem_req_o), 32'h1);

    tick();
    checkPipe("fetch0", 2'd1, 24'h000001, 1'b1, 24'h000000, 4'b0000);
    checkOutput("fetch0.instr", 32'(ifid_instr_o), 32'(24'h000000 ^ KEY));
    tick();
    checkPipe("fetch1", 2'd1, 24'h000002, 1'b1, 24'h000001, 4'b0001);
    tick();
    checkPipe("fetch2", 2'd1, 24'h000003, 1'b1, 24'h000002, 4'b0011);
    tick();
    checkPipe("fetch3", 2'd1, 24'h000004, 1'b1, 24'h000003, 4'b0111);
    tick();
    checkPipe("fetch4", 2'd1, 24'h000005, 1'b1, 24'h000004, 4'b1111);

    // One-cycle load-use stall at PC=5.
    applyStimulus(1'b1, 1'b0, 24'h0, 1'b1);
    tick();
    checkPipe("stall", 2'd1, 24'h000005, 1'b1, 24'h000004, 4'b1110);
    checkCounters("stall", 16'd1, 16'd0);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
    tick();
    checkPipe("resume", 2'd1, 24'h000006, 1'b1, 24'h000005, 4'b1101);
    checkOutput("resume.instr", 32'(ifid_instr_o), 32'(24'h000005 ^ KEY));
    tick();
    checkPipe("steady", 2'd1, 24'h000007, 1'b1, 24'h000006, 4'b1011);

    // Taken branch to 0x100: ID/EX, EX/MEM squashed; EX/MEM (1) moves to MEM/WB.
    applyStimulus(1'b0, 1'b1, 24'h000100, 1'b1);
    tick();
    checkPipe("flush", 2'd1, 24'h000100, 1'b0, 24'h000006, 4'b0100);
    checkCounters("flush", 16'd1, 16'd1);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
    tick();
    checkPipe("target", 2'd1, 24'h000101, 1'b1, 24'h000100, 4'b1000);
    checkOutput("target.instr", 32'(ifid_instr_o), 32'(24'h000100 ^ KEY));

    // Stall and flush together: flush wins, stall not counted.
    applyStimulus(1'b1, 1'b1, 24'h000200, 1'b1);
    tick();
    checkPipe("both", 2'd1, 24'h000200, 1'b0, 24'h000100, 4'b0000);
    checkCounters("both", 16'd1, 16'd2);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
    tick();
    checkPipe("both.after", 2'd1, 24'h000201, 1'b1, 24'h000200, 4'b0000);

    // Memory not ready for three cycles, then flush while waiting.
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
    tick();
    checkPipe("wait1", 2'd2, 24'h000201, 1'b0, 24'h000200, 4'b0001);
    checkOutput("wait1.req", 32'(imem_req_o), 32'h1);
    tick();
    checkPipe("wait2", 2'd2, 24'h000201, 1'b0, 24'h000200, 4'b0010);
    tick();
    checkPipe("wait3", 2'd2, 24'h000201, 1'b0, 24'h000200, 4'b0100);
    applyStimulus(1'b0, 1'b1, 24'h000300, 1'b0);
    tick();
    checkPipe("waitflush", 2'd1, 24'h000300, 1'b0, 24'h000200, 4'b1000);
    checkCounters("waitflush", 16'd1, 16'd3);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
    tick();
    checkPipe("waitflush.fetch", 2'd1, 24'h000301, 1'b1, 24'h000300, 4'b0000);

    // PC wrap at the top of the address space.
    applyStimulus(1'b0, 1'b1, 24'hFFFFFF, 1'b1);
    tick();
    checkOutput("wrap.addr_pre", 32'(imem_addr_o), 32'h00FFFFFF);
    checkCounters("wrap", 16'd1, 16'd4);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
    tick();
    checkPipe("wrap", 2'd1, 24'h000000, 1'b1, 24'hFFFFFF, 4'b0000);
    checkOutput("wrap.instr", 32'(ifid_instr_o), 32'h00A5A5A5);

    // Asynchronous reset while waiting on memory.
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
    tick();
    checkOutput("prereset.state", 32'(state_o), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checkPipe("asyncreset", 2'd0, 24'h000000, 1'b0, 24'h0, 4'b0000);
    checkOutput("asyncreset.req", 32'(imem_req_o), 32'h0);
    checkOutput("asyncreset.instr", 32'(ifid_instr_o), 32'h0);
    checkCounters("asyncreset", 16'h0, 16'h0);

    // Stall held from reset release: the IDLE edge is not counted, then saturate.
    applyStimulus(1'b1, 1'b0, 24'h0, 1'b1);
    rst_n = 1'b1;
    tick();
    checkOutput("sat.idle_ignored", 32'(stall_cnt_o), 32'h0);
    for (int i = 0; i < 65534; i++) begin
      tick();
    end
    checkOutput("sat.fffe", 32'(stall_cnt_o), 32'h0000FFFE);
    checkOutput("sat.addr_held", 32'(imem_addr_o), 32'h0);
    tick();
    checkOutput("sat.ffff", 32'(stall_cnt_o), 32'h0000FFFF);
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    checkOutput("sat.hold", 32'(stall_cnt_o), 32'h0000FFFF);
    checkOutput("sat.flush_cnt", 32'(flush_cnt_o), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
